// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : latch_write_arbiter
//  Purpose  : Shares one bank of transparent D latches among NUM_REQ writers
//             with a setup/enable/hold write sequence. d is never changed
//             while enable is high.
//  Options  : LATCH_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
//             wins) instead of the default round-robin arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module latch_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [DATA_W-1:0]            latch_d,
    output logic                         latch_enable,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner
);

    localparam int OW = $clog2(NUM_REQ);
    localparam logic [3:0]         C_SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0]         C_HOLD_LAST  = 4'(HOLD_CYC - 1);
    localparam logic [NUM_REQ-1:0] C_ONE        = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [OW-1:0]       w_winner;
    logic                w_found;
    logic [NUM_REQ-1:0]  w_owner_onehot;

`ifndef LATCH_ARB_FIXED_PRIO_EN
    logic [OW-1:0]       r_rr;
    logic [OW-1:0]       w_rr_next;

    assign w_rr_next = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif

    assign w_owner_onehot = C_ONE << owner;

    // First requester found in search order wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
            if (!w_found && req[i]) begin
                w_found  = 1'b1;
                w_winner = OW'(i);
            end
`else
            if (!w_found && req[(int'(r_rr) + i) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = OW'((int'(r_rr) + i) % NUM_REQ);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            grant        <= '0;
            latch_d      <= '0;
            latch_enable <= 1'b0;
            busy         <= 1'b0;
            owner        <= '0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            r_rr         <= '0;
`endif
        end else begin
            grant <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        latch_d <= req_data[w_winner*DATA_W +: DATA_W];
                        owner   <= w_winner;
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == C_SETUP_LAST) begin
                        r_cnt        <= '0;
                        latch_enable <= 1'b1;
                        r_state      <= ENABLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ENABLE: begin
                    latch_enable <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= HOLD;
                    // A one-cycle hold makes the first HOLD cycle the grant cycle.
                    if (C_HOLD_LAST == 4'd0) begin
                        grant <= w_owner_onehot;
                    end
                end
                HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= IDLE;
`ifndef LATCH_ARB_FIXED_PRIO_EN
                        r_rr    <= w_rr_next;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == C_HOLD_LAST) begin
                            grant <= w_owner_onehot;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
